// File: rtl/tick_counter_pkg.sv
// Shared constants and types for the tick_counter slice.
// TICK_COUNTER_SYNC_EN selects a 2-flop input synchronizer; without it div_in is sampled by a single flop.
package tick_counter_pkg;

   localparam int DEF_WIDTH   = 4;
   localparam int DEF_MODULUS = 10;

   typedef enum logic {
      DIR_DOWN = 1'b0,
      DIR_UP   = 1'b1
   } dir_t;

`ifdef TICK_COUNTER_SYNC_EN
   localparam int SYNC_STAGES = 2;
`else
   localparam int SYNC_STAGES = 1;
`endif

endpackage

// File: rtl/edge_tick.sv
// Samples the divided clock level and emits a one-cycle tick per rising edge.
// TICK_COUNTER_SYNC_EN adds a second synchronizer stage ahead of the sample flop.
module edge_tick
   import tick_counter_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic div_in,
   output logic tick
);

   localparam logic [1:0] ARM_LOAD = 2'(SYNC_STAGES);

   logic       s2;
   logic       d;
   logic       armed;
   logic [1:0] arm_cnt;

`ifdef TICK_COUNTER_SYNC_EN
   logic s1;

   always_ff @(posedge clk) begin
      if (!rst) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
      end else begin
         s1 <= div_in;
         s2 <= s1;
      end
   end
`else
   always_ff @(posedge clk) begin
      if (!rst) begin
         s2 <= 1'b0;
      end else begin
         s2 <= div_in;
      end
   end
`endif

   // armed rises on the same edge that d first catches up with a level already high at release
   always_ff @(posedge clk) begin
      if (!rst) begin
         d       <= 1'b0;
         armed   <= 1'b0;
         arm_cnt <= ARM_LOAD;
      end else begin
         d <= s2;
         if (arm_cnt != 2'd0) begin
            arm_cnt <= arm_cnt - 2'd1;
         end else begin
            armed <= 1'b1;
         end
      end
   end

   assign tick = armed & s2 & ~d;

endmodule

// File: rtl/tick_counter.sv
// Modulo-MODULUS up/down counter advanced by ticks derived from the divided clock level.
// Input synchronizer depth is set by TICK_COUNTER_SYNC_EN (see edge_tick).
module tick_counter
   import tick_counter_pkg::*;
#(
   parameter int WIDTH   = DEF_WIDTH,
   parameter int MODULUS = DEF_MODULUS
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             div_in,
   input  logic             en,
   input  logic             up,
   input  logic             ld,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] count,
   output logic             tick,
   output logic             tc
);

   localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);
   localparam logic [WIDTH-1:0] CNT_MAX = WIDTH'(MODULUS - 1);

   logic [WIDTH-1:0] count_nxt;
   logic             tc_nxt;
   dir_t             dir;

   assign dir = dir_t'(up);

   edge_tick u_edge_tick (
      .clk    (clk),
      .rst    (rst),
      .div_in (div_in),
      .tick   (tick)
   );

   // a load swallows any coincident tick
   always_comb begin
      count_nxt = count;
      tc_nxt    = 1'b0;
      if (ld) begin
         count_nxt = ({1'b0, din} < MOD_EXT) ? din : '0;
      end else if (en && tick) begin
         if (dir == DIR_UP) begin
            if (count == CNT_MAX) begin
               count_nxt = '0;
               tc_nxt    = 1'b1;
            end else begin
               count_nxt = count + 1'b1;
            end
         end else begin
            if (count == '0) begin
               count_nxt = CNT_MAX;
               tc_nxt    = 1'b1;
            end else begin
               count_nxt = count - 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         count <= '0;
         tc    <= 1'b0;
      end else begin
         count <= count_nxt;
         tc    <= tc_nxt;
      end
   end

endmodule

// File: tb/tb_tick_counter.sv
// Self-checking bench for tick_counter: directed scenarios then randomized traffic against an event-queue model.
module tb_tick_counter;
   import tick_counter_pkg::*;

   localparam int W = DEF_WIDTH;
   localparam int M = DEF_MODULUS;
   localparam int L = SYNC_STAGES;

   logic         clk    = 1'b0;
   logic         rst    = 1'b0;
   logic         div_in = 1'b0;
   logic         en     = 1'b0;
   logic         up     = 1'b1;
   logic         ld     = 1'b0;
   logic [W-1:0] din    = '0;
   logic [W-1:0] count;
   logic         tick;
   logic         tc;

   int n_assert  = 0;
   int n_fail    = 0;
   int tick_seen = 0;

   // reference model: counter value, tc, and a queue of edges at which ticks reach the counter
   int m_cnt  = 0;
   bit m_tc   = 1'b0;
   bit m_prev = 1'b0;
   int m_edge = 0;
   int m_q[$];

   tick_counter #(.WIDTH(W), .MODULUS(M)) dut (
      .clk    (clk),
      .rst    (rst),
      .div_in (div_in),
      .en     (en),
      .up     (up),
      .ld     (ld),
      .din    (din),
      .count  (count),
      .tick   (tick),
      .tc     (tc)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic bit m_tick_next();
      return (m_q.size() > 0 && m_q[0] == m_edge + 1);
   endfunction

   task automatic cyc();
      bit due;
      @(posedge clk);
      if (!rst) begin
         m_cnt  = 0;
         m_tc   = 1'b0;
         m_prev = 1'b0;
         m_edge = 0;
         m_q.delete();
      end else begin
         m_edge++;
         due = (m_q.size() > 0 && m_q[0] == m_edge);
         if (due) void'(m_q.pop_front());
         m_tc = 1'b0;
         if (ld) begin
            m_cnt = (int'(din) < M) ? int'(din) : 0;
         end else if (en && due) begin
            if (up) begin
               m_tc  = (m_cnt == M - 1);
               m_cnt = (m_cnt + 1) % M;
            end else begin
               m_tc  = (m_cnt == 0);
               m_cnt = (m_cnt + M - 1) % M;
            end
         end
         // the first edge after release cannot produce a tick: the level may simply have been high at reset
         if (div_in && !m_prev && m_edge >= 2) m_q.push_back(m_edge + L);
         m_prev = div_in;
      end
      #1;
      if (tick === 1'b1) tick_seen++;
      check("count", count, m_cnt);
      check("tc", tc, m_tc);
      check("tick", tick, m_tick_next());
   endtask

   task automatic hold(input int n, input logic lvl);
      div_in = lvl;
      repeat (n) cyc();
   endtask

   task automatic wait_tick();
      for (int i = 0; i < 10 && !m_tick_next(); i++) cyc();
      check("tick_wait", tick, 1);
   endtask

   initial begin
      // reset with div_in already high, then hold it high after release
      rst = 1'b0; div_in = 1'b1;
      repeat (3) cyc();
      rst = 1'b1;
      tick_seen = 0;
      repeat (10) cyc();
      check("no_false_tick", tick_seen, 0);
      check("idle_count", count, 0);

      // count up from 8 through the wrap
      en = 1'b1; up = 1'b1; ld = 1'b1; din = W'(8);
      cyc();
      ld = 1'b0;
      hold(4, 1'b0);
      repeat (3) begin
         hold(4, 1'b1);
         hold(4, 1'b0);
      end
      check("up_wrap_end", count, 1);

      // count down from 0 wraps to MODULUS-1
      up = 1'b0; ld = 1'b1; din = W'(0);
      cyc();
      ld = 1'b0;
      hold(4, 1'b1);
      hold(4, 1'b0);
      check("down_wrap", count, M - 1);

      // load coincident with a tick, then out-of-range load
      up = 1'b1; div_in = 1'b1;
      wait_tick();
      ld = 1'b1; din = W'(7);
      cyc();
      ld = 1'b0;
      check("ld_vs_tick", count, 7);
      check("ld_vs_tick_tc", tc, 0);
      ld = 1'b1; din = W'(12);
      cyc();
      ld = 1'b0;
      check("ld_oor", count, 0);
      hold(3, 1'b0);

      // ticks keep firing with en low, count frozen
      ld = 1'b1; din = W'(3);
      cyc();
      ld = 1'b0; en = 1'b0;
      tick_seen = 0;
      repeat (5) begin
         hold(3, 1'b1);
         hold(3, 1'b0);
      end
      check("en0_ticks", tick_seen, 5);
      check("en0_count", count, 3);

      // reset lands just before a pending tick reaches the counter
      en = 1'b1; up = 1'b1; ld = 1'b1; din = W'(5);
      cyc();
      ld = 1'b0;
      hold(3, 1'b0);
      div_in = 1'b1;
      wait_tick();
      rst = 1'b0;
      cyc();
      rst = 1'b1;
      check("rst_count", count, 0);
      tick_seen = 0;
      hold(6, 1'b1);
      check("rst_no_tick", tick_seen, 0);
      hold(3, 1'b0);
      hold(3, 1'b1);
      hold(3, 1'b0);
      check("post_rst", count, 1);

      // randomized traffic
      repeat (80) begin
         int n;
         div_in = ~div_in;
         n = $urandom_range(2, 6);
         repeat (n) begin
            en  = ($urandom_range(0, 3) != 0);
            up  = $urandom_range(0, 1);
            ld  = ($urandom_range(0, 15) == 0);
            din = W'($urandom_range(0, (1 << W) - 1));
            rst = ($urandom_range(0, 127) != 0);
            cyc();
         end
      end
      rst = 1'b1; ld = 1'b0;
      repeat (4) cyc();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
